id_stage_hs: RTL and testbench

Parametrised decode stage for core_lapido, the successor to the fixed-width ID stage. It holds one fetched instruction in an internal decode register and exposes opcode/funct to the shared control_unit. It registers the control bundle and instruction fields into an ID/EX output register. Unlike its predecessor, it uses valid/ready handshakes on both sides, holds state on hazard stalls, flushes on taken branches, clamps register addresses to a parametrised register-file size, and selects sign or zero immediate extension.

---
 rtl/id_stage_hs_pkg.sv | 32 +++
 rtl/id_stage_hs_pipe_reg.sv | 75 +++++++
 rtl/id_stage_hs.sv | 136 +++++++++++++
 tb/tb_id_stage_hs.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_hs_pkg.sv
// id_stage_hs_pkg
// Shared definitions for the core_lapido decode stage: instruction field
// positions, default widths and the register-address clamp helper.
// No ports (package).
package id_stage_hs_pkg;

    // Default widths
    localparam int DEF_IW       = 32;
    localparam int DEF_PCW      = 32;
    localparam int DEF_DW       = 32;
    localparam int DEF_AW       = 5;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_CTRL_W   = 24;

    // Instruction field layout
    localparam int OPC_W   = 6;   // opcode sits in the top OPC_W bits
    localparam int FUNCT_W = 6;   // funct sits in the bottom FUNCT_W bits
    localparam int FIELD_W = 5;   // rs / rt / rd field width
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_W   = 16;
    localparam int JTARG_W = 26;  // absolute jump target field

    // Register numbers beyond the implemented file map onto the last register.
    function automatic logic [FIELD_W-1:0] clamp_reg(input logic [FIELD_W-1:0] f,
                                                     input int num_regs);
        if (int'(f) < num_regs) return f;
        else return FIELD_W'(num_regs - 1);
    endfunction

endpackage

// File: rtl/id_stage_hs_pipe_reg.sv
// id_pipe_reg
// Generic valid/ready pipeline register with bubble insertion and flush.
// The "ctrl" part is zeroed on every bubble/flush so downstream sees a
// harmless control word; the payload part only changes on a load.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load_i     upstream hands a new entry this cycle (caller guarantees free_o)
//   flush_i    kill the held entry (highest priority)
//   ready_i    downstream accepts the held entry
//   ctrl_i     control word to load
//   pay_i      payload to load
//   free_o     register can take a new entry this cycle
//   valid_o    register holds a real entry
//   ctrl_o     held control word (0 while not valid)
//   pay_o      held payload
// Handshake: an entry leaves when valid_o && ready_i at a rising clk edge;
// while valid_o && !ready_i every output is held stable.
module id_pipe_reg #(
    parameter int CW = 24,
    parameter int PW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          flush_i,
    input  logic          ready_i,
    input  logic [CW-1:0] ctrl_i,
    input  logic [PW-1:0] pay_i,
    output logic          free_o,
    output logic          valid_o,
    output logic [CW-1:0] ctrl_o,
    output logic [PW-1:0] pay_o
);

    logic          valid_q, valid_d;
    logic [CW-1:0] ctrl_q,  ctrl_d;
    logic [PW-1:0] pay_q,   pay_d;

    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pay_d   = pay_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            pay_d   = pay_i;
        end else if (free_o) begin
            // Nothing new to send and the old entry is gone: bubble.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign pay_o   = pay_q;

endmodule

// File: rtl/id_stage_hs.sv
// id_stage_hs
// core_lapido decode stage. Holds one instruction in the decode register D,
// hands opcode/funct to the external control_unit, and moves the returned
// control bundle plus decoded fields into the ID/EX register E.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc   IF -> ID handshake
//   flush                         taken branch: kill D and E
//   hazard_stall                  hold D, send a bubble to EX
//   opcode, funct                 D fields to control_unit
//   ctrl_in, ctrl_is_jump, ctrl_sel_j_jr, ctrl_imm_zext   control_unit results
//   rs_addr, rt_addr, rs_data     register-file read (addresses clamped)
//   jump_valid, jump_addr         IF redirect
//   out_valid/out_ready + out_*   ID -> EX handshake and payload
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready; a producer holds valid and data stable until it transfers.
module id_stage_hs import id_stage_hs_pkg::*; #(
    parameter int IW       = DEF_IW,
    parameter int PCW      = DEF_PCW,
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CTRL_W   = DEF_CTRL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IW-1:0]      in_instr,
    input  logic [PCW-1:0]     in_pc,
    input  logic               flush,
    input  logic               hazard_stall,
    output logic [OPC_W-1:0]   opcode,
    output logic [FUNCT_W-1:0] funct,
    input  logic [CTRL_W-1:0]  ctrl_in,
    input  logic               ctrl_is_jump,
    input  logic               ctrl_sel_j_jr,
    input  logic               ctrl_imm_zext,
    output logic [AW-1:0]      rs_addr,
    output logic [AW-1:0]      rt_addr,
    input  logic [DW-1:0]      rs_data,
    output logic               jump_valid,
    output logic [PCW-1:0]     jump_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [FIELD_W-1:0] out_rd,
    output logic [FIELD_W-1:0] out_rs,
    output logic [FIELD_W-1:0] out_rt,
    output logic [DW-1:0]      out_imm,
    output logic [PCW-1:0]     out_next_pc
);

    localparam int PW = 3 * FIELD_W + DW + PCW;

    logic           d_valid_q, d_valid_d;
    logic [IW-1:0]  d_instr_q, d_instr_d;
    logic [PCW-1:0] d_pc_q,    d_pc_d;

    logic               e_free, adv, accept;
    logic [FIELD_W-1:0] rs_f, rt_f, rd_f;
    logic [IMM_W-1:0]   imm16;
    logic [DW-1:0]      imm_ext;
    logic [PW-1:0]      e_pay;

    // D moves on only when E can take it and nothing holds or kills it.
    assign adv        = d_valid_q && e_free && !hazard_stall && !flush;
    assign jump_valid = adv && ctrl_is_jump;
    // Closed during a jump so no wrong-path instruction is accepted, and
    // during reset so IF sees no acceptance while state is being cleared.
    assign in_ready   = !rst && !flush && !jump_valid && (!d_valid_q || adv);
    assign accept     = in_valid && in_ready;

    always_comb begin
        d_valid_d = d_valid_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        if (flush) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = in_instr;
            d_pc_d    = in_pc;
        end else if (adv) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
            d_pc_q    <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
        end
    end

    // Decode of D; driven even when D is empty (the bubble makes it harmless).
    assign opcode = d_instr_q[IW-1 -: OPC_W];
    assign funct  = d_instr_q[FUNCT_W-1:0];
    assign rs_f   = d_instr_q[RS_LSB +: FIELD_W];
    assign rt_f   = d_instr_q[RT_LSB +: FIELD_W];
    assign rd_f   = d_instr_q[RD_LSB +: FIELD_W];
    assign imm16  = d_instr_q[IMM_W-1:0];

    assign rs_addr = AW'(clamp_reg(rs_f, NUM_REGS));
    assign rt_addr = AW'(clamp_reg(rt_f, NUM_REGS));

    assign imm_ext = ctrl_imm_zext ? {{(DW-IMM_W){1'b0}}, imm16}
                                   : {{(DW-IMM_W){imm16[IMM_W-1]}}, imm16};

    assign jump_addr = ctrl_sel_j_jr ? PCW'(d_instr_q[JTARG_W-1:0]) : rs_data[PCW-1:0];

    id_pipe_reg #(
        .CW (CTRL_W),
        .PW (PW)
    ) u_e_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (adv),
        .flush_i (flush),
        .ready_i (out_ready),
        .ctrl_i  (ctrl_in),
        .pay_i   ({rd_f, rs_f, rt_f, imm_ext, d_pc_q + PCW'(1)}),
        .free_o  (e_free),
        .valid_o (out_valid),
        .ctrl_o  (out_ctrl),
        .pay_o   (e_pay)
    );

    assign {out_rd, out_rs, out_rt, out_imm, out_next_pc} = e_pay;

endmodule

// File: tb/tb_id_stage_hs.sv
module tb_id_stage_hs;

    localparam int IW       = 32;
    localparam int PCW      = 32;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 16;
    localparam int CTRL_W   = 24;
    localparam int EXP_W    = CTRL_W + 15 + DW + PCW;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [IW-1:0]     in_instr;
    logic [PCW-1:0]    in_pc;
    logic              flush, hazard_stall;
    logic [5:0]        opcode, funct;
    logic [CTRL_W-1:0] ctrl_in;
    logic              ctrl_is_jump, ctrl_sel_j_jr, ctrl_imm_zext;
    logic [AW-1:0]     rs_addr, rt_addr;
    logic [DW-1:0]     rs_data;
    logic              jump_valid;
    logic [PCW-1:0]    jump_addr;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_rd, out_rs, out_rt;
    logic [DW-1:0]     out_imm;
    logic [PCW-1:0]    out_next_pc;

    always #5 clk = ~clk;

    id_stage_hs #(
        .IW(IW), .PCW(PCW), .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS), .CTRL_W(CTRL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .hazard_stall(hazard_stall),
        .opcode(opcode), .funct(funct),
        .ctrl_in(ctrl_in), .ctrl_is_jump(ctrl_is_jump),
        .ctrl_sel_j_jr(ctrl_sel_j_jr), .ctrl_imm_zext(ctrl_imm_zext),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm(out_imm), .out_next_pc(out_next_pc)
    );

    // ---------------- reference model ----------------
    // Stand-in control_unit: an arbitrary but opcode/funct-dependent bundle.
    function automatic logic [CTRL_W-1:0] cu_ctrl(input logic [5:0] op, input logic [5:0] fn);
        return {op, fn, op ^ fn, 6'h2A};
    endfunction

    // Stand-in register file contents.
    function automatic logic [DW-1:0] rf_val(input int r);
        return 32'hC000_0000 | (32'(r) * 32'h0001_0101);
    endfunction

    function automatic int ref_clamp(input int r);
        return (r < NUM_REGS) ? r : NUM_REGS - 1;
    endfunction

    // Expected EX-side beat for an accepted instruction.
    function automatic logic [EXP_W-1:0] exp_of(input logic [31:0] ins, input logic [31:0] pc);
        int imm;
        logic [31:0] imm_v;
        imm = int'(ins[15:0]);
        if (ins[31:26] != 6'h0D && imm >= 32768) imm = imm - 65536;
        imm_v = 32'(imm);
        return {cu_ctrl(ins[31:26], ins[5:0]), ins[15:11], ins[25:21], ins[20:16],
                imm_v, pc + 32'd1};
    endfunction

    always_comb begin
        ctrl_in       = cu_ctrl(opcode, funct);
        ctrl_imm_zext = (opcode == 6'h0D);
        ctrl_sel_j_jr = (opcode == 6'h02);
        ctrl_is_jump  = (opcode == 6'h02) || (opcode == 6'h00 && funct == 6'h08);
        rs_data       = rf_val(int'(rs_addr));
    end

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int beats = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge; inputs are stable from here to
    // the next rising edge, so this sees exactly the transfers of that edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    beats++;
                    if (exp_q.size() == 0)
                        check("out_unexpected", 1, 0);
                    else
                        check("out_beat", {out_ctrl, out_rd, out_rs, out_rt, out_imm, out_next_pc},
                              exp_q.pop_front());
                end
                if (flush) exp_q.delete();
                if (in_valid && in_ready) exp_q.push_back(exp_of(in_instr, in_pc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 4))
            0: op = 6'h08;
            1: op = 6'h0D;
            2: op = 6'h00;
            3: op = 6'h23;
            default: op = 6'h02;
        endcase
        return {op, 26'($urandom())};
    endfunction

    localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd3, 16'hFFFE};
    localparam logic [31:0] I_ORI  = {6'h0D, 5'd2, 5'd4, 16'h8000};
    localparam logic [31:0] I_C    = {6'h08, 5'd6, 5'd5, 16'h0007};
    localparam logic [31:0] I_E1   = {6'h08, 5'd7, 5'd8, 16'h1234};
    localparam logic [31:0] I_J    = {6'h02, 26'h0000123};
    localparam logic [31:0] I_JR   = {6'h00, 5'd20, 5'd31, 5'd0, 5'd0, 6'h08};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0);
        flush = 1'b0;
        hazard_stall = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", in_ready, 1);

        // Streaming: sign- then zero-extended immediates, one per cycle
        drive(1'b1, I_ADDI, 32'h100);
        step();
        drive(1'b1, I_ORI, 32'h101);
        step();
        drive(1'b0, '0, '0);
        settle();
        check("addi_valid", out_valid, 1);
        check("addi_imm", out_imm, 32'hFFFF_FFFE);
        check("addi_next_pc", out_next_pc, 32'h101);
        step();
        check("ori_valid", out_valid, 1);
        check("ori_imm", out_imm, 32'h0000_8000);
        check("ori_next_pc", out_next_pc, 32'h102);

        // Hazard stall: two bubbles, D held, then it issues
        drive(1'b1, I_C, 32'h300);
        step();
        hazard_stall = 1'b1;
        drive(1'b1, I_ADDI, 32'h301);
        settle();
        check("stall_in_ready", in_ready, 0);
        step();
        check("stall_bubble1_valid", out_valid, 0);
        check("stall_bubble1_ctrl", out_ctrl, 0);
        step();
        check("stall_bubble2_valid", out_valid, 0);
        hazard_stall = 1'b0;
        settle();
        check("unstall_in_ready", in_ready, 1);
        step();
        drive(1'b0, '0, '0);
        check("unstall_issue_valid", out_valid, 1);
        check("unstall_issue_pc", out_next_pc, 32'h301);
        repeat (2) step();

        // Back-pressure: E holds, D holds, nothing lost
        drive(1'b1, I_E1, 32'h400);
        step();
        drive(1'b1, I_ADDI, 32'h401);
        step();
        out_ready = 1'b0;
        drive(1'b1, I_ORI, 32'h402);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_imm", out_imm, 32'h0000_1234);
            step();
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_in_ready", in_ready, 1);
        step();
        drive(1'b0, '0, '0);
        repeat (3) step();

        // Flush beats stall and back-pressure
        drive(1'b1, I_C, 32'h500);
        step();
        drive(1'b1, I_E1, 32'h501);
        step();
        drive(1'b0, '0, '0);
        flush = 1'b1;
        hazard_stall = 1'b1;
        out_ready = 1'b0;
        settle();
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        hazard_stall = 1'b0;
        out_ready = 1'b1;
        settle();
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_d_empty", in_ready, 1);
        step();
        check("flush_no_reissue", out_valid, 0);

        // Jumps: absolute j, then jr through a clamped register
        drive(1'b1, I_J, 32'h600);
        step();
        drive(1'b1, I_ADDI, 32'h601);
        settle();
        check("j_valid", jump_valid, 1);
        check("j_addr", jump_addr, 32'h123);
        check("j_in_ready", in_ready, 0);
        step();
        drive(1'b1, I_JR, 32'h602);
        settle();
        check("after_j_in_ready", in_ready, 1);
        step();
        drive(1'b0, '0, '0);
        settle();
        check("jr_opcode", opcode, 6'h00);
        check("jr_funct", funct, 6'h08);
        check("jr_rs_addr", rs_addr, ref_clamp(20));
        check("jr_rt_addr", rt_addr, ref_clamp(31));
        check("jr_valid", jump_valid, 1);
        check("jr_addr", jump_addr, rf_val(ref_clamp(20)));
        repeat (3) step();

        // Reset in the middle of traffic
        drive(1'b1, I_ORI, 32'h700);
        step();
        drive(1'b0, '0, '0);
        out_ready = 1'b0;
        step();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        settle();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_ctrl", out_ctrl, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        settle();
        check("mid_rst_release_in_ready", in_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom());
            out_ready    = ($urandom_range(0, 3) != 0);
            hazard_stall = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 29) == 0);
            step();
        end

        // Drain and final accounting
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        hazard_stall = 1'b0;
        flush = 1'b0;
        repeat (6) step();
        check("drain_queue_empty", exp_q.size(), 0);
        check("enough_beats", beats > 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
